pmem_arbiter: RTL and testbench
===============================

Name: pmem_arbiter

Overview:
- Two-port arbiter between the split instruction/data caches and the single physical-memory port of the mp3 top level.
- Serializes cache-line fills and writebacks from the I-cache (read-only) and D-cache (read/write) onto one pmem_read/pmem_write/pmem_resp handshake.
- Uses round-robin arbitration on simultaneous requests.
- Latches each granted request so the pmem side sees stable address/data for the whole transaction.

Parameters:
- ADDR_WIDTH, 16, byte address width (lc3b_word).
- LINE_WIDTH, 128, cache-line width (pmem_bus).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- i_pmem_address  in  ADDR_WIDTH  I-cache line address.
- i_pmem_read  in  1  I-cache line-fill request; held until i_pmem_resp.
- i_pmem_rdata  out  LINE_WIDTH  fill data to I-cache.
- i_pmem_resp  out  1  one-cycle completion pulse to I-cache.
- d_pmem_address  in  ADDR_WIDTH  D-cache line address.
- d_pmem_read  in  1  D-cache fill request; held until d_pmem_resp.
- d_pmem_write  in  1  D-cache writeback request; held until d_pmem_resp.
- d_pmem_wdata  in  LINE_WIDTH  writeback line.
- d_pmem_rdata  out  LINE_WIDTH  fill data to D-cache.
- d_pmem_resp  out  1  one-cycle completion pulse to D-cache.
- pmem_address  out  ADDR_WIDTH  latched address to physical memory.
- pmem_read  out  1  registered read strobe.
- pmem_write  out  1  registered write strobe.
- pmem_wdata  out  LINE_WIDTH  latched writeback line.
- pmem_rdata  in  LINE_WIDTH  line returned by memory.
- pmem_resp  in  1  memory completion.

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is synchronous and active-high (rst). While rst is sampled high:
  - state goes to IDLE;
  - pmem_read, pmem_write, i_pmem_resp and d_pmem_resp are 0;
  - pmem_address and pmem_wdata are 0;
  - last_grant = I, so the first tie goes to D.
  - Reset mid-transaction abandons it: no resp pulse is issued, and the strobes drop the next cycle.
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE decision, each cycle:
  - d_req = d_pmem_read | d_pmem_write; i_req = i_pmem_read.
  - Only d_req: grant D. Only i_req: grant I.
  - Both: grant the port not equal to last_grant.
  - Neither: stay in IDLE.
- On grant (edge leaving IDLE):
  - Latch pmem_address from the winner's address.
  - Latch pmem_wdata from d_pmem_wdata (D) or hold the previous value (I).
  - Set pmem_read/pmem_write from the winner's op.
  - Update last_grant to the winner.
  - If D asserts both read and write, write wins (pmem_write=1, pmem_read=0).
- SERVE_x:
  - Strobes and latched address/data are held constant; requester inputs are not re-sampled.
  - When pmem_resp=1, the winner's resp is driven combinationally high in that same cycle.
  - On the next edge: clear the strobes, return to IDLE.
- Read data: i_pmem_rdata and d_pmem_rdata are continuous copies of pmem_rdata. Data is valid only in the resp cycle.
- Latency:
  - Request first sampled in IDLE at cycle N; pmem strobe high from cycle N+1.
  - Requester resp is high in the same cycle as pmem_resp.
  - Minimum one IDLE cycle between back-to-back transactions, so a requester that drops its request on resp is never re-granted spuriously.
- Boundary conditions:
  - A non-granted requester waits; its resp stays 0.
  - A requester deasserting mid-transaction does not abort it; the transaction completes and resp still pulses.
  - pmem_resp while in IDLE is ignored.
  - The non-winning resp is always 0.
  - Continuous contention strictly alternates I/D, so there is no starvation.

Test Plan:
- Reset then idle: hold rst 2 cycles with i_pmem_read=1 -> no strobes during reset. First grant is I at the first post-reset IDLE cycle; pmem_read=1 one cycle later.
- Single I fill: i_pmem_address=0x1230, i_pmem_read=1; memory returns pmem_rdata=128'hDEAD_BEEF pattern with pmem_resp after 5 cycles -> pmem_address=0x1230, pmem_read high 5 cycles, pmem_write=0. i_pmem_resp pulses 1 cycle with i_pmem_rdata equal to the pattern; d_pmem_resp=0 throughout.
- D writeback: d_pmem_write=1, address 0x8040, wdata=128'h0123...CDEF -> pmem_write=1 with that address/data, held stable while the bench toggles d_pmem_wdata. d_pmem_resp coincides with pmem_resp.
- Simultaneous requests after reset: I read 0x0100 and D read 0x2000 in the same cycle -> D served first (0x2000), then IDLE for one cycle, then I (0x0100). The next tie goes to D again.
- Starvation check: D re-requests immediately after each resp while I holds its request -> grants alternate D, I, D, I over 4 transactions.
- Reset mid-operation: rst asserted during SERVE_D before pmem_resp -> the next cycle has pmem_write=0 and state IDLE; d_pmem_resp never pulses.

Source files
------------

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter between the I-cache and D-cache line ports and the single
// physical-memory port. Each granted request is latched for the whole transaction.
//
//  state   | meaning
//  --------+--------------------------------------------------------------
//  IDLE    | no transaction; requests sampled and arbitrated every cycle
//  SERVE_I | I-cache fill on pmem, waiting for pmem_resp
//  SERVE_D | D-cache fill or writeback on pmem, waiting for pmem_resp
module pmem_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int LINE_WIDTH = 128
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic [ADDR_WIDTH-1:0] i_pmem_address,
   input  logic                  i_pmem_read,
   output logic [LINE_WIDTH-1:0] i_pmem_rdata,
   output logic                  i_pmem_resp,

   input  logic [ADDR_WIDTH-1:0] d_pmem_address,
   input  logic                  d_pmem_read,
   input  logic                  d_pmem_write,
   input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
   output logic [LINE_WIDTH-1:0] d_pmem_rdata,
   output logic                  d_pmem_resp,

   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
   typedef enum logic {GRANT_I, GRANT_D} grant_t;

   state_t                  state_q, state_d;
   grant_t                  last_q, last_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [LINE_WIDTH-1:0]   wdata_q, wdata_d;
   logic                    rd_q, rd_d;
   logic                    wr_q, wr_d;
   logic                    d_req, i_req;
   logic                    pick_d;

   assign d_req  = d_pmem_read | d_pmem_write;
   assign i_req  = i_pmem_read;
   // On a tie the port that did not win last time goes first.
   assign pick_d = d_req & (~i_req | (last_q == GRANT_I));

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      i_pmem_resp = 1'b0;
      d_pmem_resp = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_d) begin
               state_d = SERVE_D;
               last_d  = GRANT_D;
               addr_d  = d_pmem_address;
               wdata_d = d_pmem_wdata;
               wr_d    = d_pmem_write;
               rd_d    = d_pmem_read & ~d_pmem_write;
            end else if (i_req) begin
               state_d = SERVE_I;
               last_d  = GRANT_I;
               addr_d  = i_pmem_address;
               rd_d    = 1'b1;
               wr_d    = 1'b0;
            end
         end
         SERVE_I: begin
            if (pmem_resp) begin
               i_pmem_resp = ~rst;
               state_d     = IDLE;
               rd_d        = 1'b0;
               wr_d        = 1'b0;
            end
         end
         SERVE_D: begin
            if (pmem_resp) begin
               d_pmem_resp = ~rst;
               state_d     = IDLE;
               rd_d        = 1'b0;
               wr_d        = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= GRANT_I;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

   assign pmem_address = addr_q;
   assign pmem_wdata   = wdata_q;
   assign pmem_read    = rd_q;
   assign pmem_write   = wr_q;
   assign i_pmem_rdata = pmem_rdata;
   assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomized bench for pmem_arbiter: the bench plays both caches and the memory,
// and predicts every pmem-side and requester-side output from a transaction model.
module tb_pmem_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [15:0]  i_pmem_address;
   logic         i_pmem_read;
   logic [127:0] i_pmem_rdata;
   logic         i_pmem_resp;
   logic [15:0]  d_pmem_address;
   logic         d_pmem_read;
   logic         d_pmem_write;
   logic [127:0] d_pmem_wdata;
   logic [127:0] d_pmem_rdata;
   logic         d_pmem_resp;
   logic [15:0]  pmem_address;
   logic         pmem_read;
   logic         pmem_write;
   logic [127:0] pmem_wdata;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;

   pmem_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_pmem_address (i_pmem_address),
      .i_pmem_read    (i_pmem_read),
      .i_pmem_rdata   (i_pmem_rdata),
      .i_pmem_resp    (i_pmem_resp),
      .d_pmem_address (d_pmem_address),
      .d_pmem_read    (d_pmem_read),
      .d_pmem_write   (d_pmem_write),
      .d_pmem_wdata   (d_pmem_wdata),
      .d_pmem_rdata   (d_pmem_rdata),
      .d_pmem_resp    (d_pmem_resp),
      .pmem_address   (pmem_address),
      .pmem_read      (pmem_read),
      .pmem_write     (pmem_write),
      .pmem_wdata     (pmem_wdata),
      .pmem_rdata     (pmem_rdata),
      .pmem_resp      (pmem_resp)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         if (n_errors <= 30)
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   // Transaction-level model: one outstanding pmem transaction at most.
   bit           m_busy, m_port, m_rd, m_wr, m_last;   // port/last: 0 = I, 1 = D
   logic [15:0]  m_addr;
   logic [127:0] m_wdata;
   bit           granted, done_i, done_d;
   int           mem_lat;
   int           n_done_i, n_done_d;

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic new_d_req();
      int op;
      op = $urandom_range(0, 7);
      d_pmem_address = 16'($urandom);
      d_pmem_wdata   = rnd128();
      d_pmem_read    = (op < 4) || (op == 7);
      d_pmem_write   = (op >= 4);
   endtask

   initial begin
      bit dreq, ireq, win_d, served_i, served_d;
      m_busy = 0; m_port = 0; m_rd = 0; m_wr = 0; m_last = 0;
      m_addr = '0; m_wdata = '0; mem_lat = 0; n_done_i = 0; n_done_d = 0;

      rst            = 1'b1;
      i_pmem_address = 16'h0100;
      i_pmem_read    = 1'b1;
      d_pmem_address = 16'h2000;
      d_pmem_read    = 1'b1;
      d_pmem_write   = 1'b0;
      d_pmem_wdata   = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
      pmem_rdata     = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
      pmem_resp      = 1'b0;

      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(posedge clk);
         // Model advance using the inputs that were stable before this edge.
         granted = 0; done_i = 0; done_d = 0;
         if (rst) begin
            m_busy = 0; m_last = 0; m_addr = '0; m_wdata = '0; m_rd = 0; m_wr = 0;
         end else if (m_busy) begin
            if (pmem_resp) begin
               m_busy = 0;
               if (m_port) begin done_d = 1; n_done_d++; end
               else begin done_i = 1; n_done_i++; end
            end
         end else begin
            dreq = d_pmem_read | d_pmem_write;
            ireq = i_pmem_read;
            win_d = (dreq && ireq) ? !m_last : dreq;
            if (dreq || ireq) begin
               m_busy = 1; granted = 1; m_port = win_d; m_last = win_d;
               if (win_d) begin
                  m_addr  = d_pmem_address;
                  m_wdata = d_pmem_wdata;
                  m_wr    = d_pmem_write;
                  m_rd    = !d_pmem_write;
               end else begin
                  m_addr = i_pmem_address;
                  m_rd   = 1; m_wr = 0;
               end
            end
         end

         #1;
         if (cyc >= 2) begin
            rst = ($urandom_range(0, 149) == 0);
            served_i = m_busy && !m_port;
            served_d = m_busy && m_port;

            if (done_i) begin
               if ($urandom_range(0, 1) == 0) i_pmem_read = 1'b0;
               else i_pmem_address = 16'($urandom);
            end else if (served_i) begin
               if ($urandom_range(0, 19) == 0) i_pmem_read = 1'b0;
               if ($urandom_range(0, 2) == 0) i_pmem_address = 16'($urandom);
            end else if (!i_pmem_read && $urandom_range(0, 3) == 0) begin
               i_pmem_read    = 1'b1;
               i_pmem_address = 16'($urandom);
            end

            if (done_d) begin
               if ($urandom_range(0, 1) == 0) begin
                  d_pmem_read = 1'b0; d_pmem_write = 1'b0;
               end else new_d_req();
            end else if (served_d) begin
               if ($urandom_range(0, 19) == 0) begin
                  d_pmem_read = 1'b0; d_pmem_write = 1'b0;
               end
               if ($urandom_range(0, 2) == 0) d_pmem_address = 16'($urandom);
               d_pmem_wdata = rnd128();
            end else if (!(d_pmem_read || d_pmem_write)) begin
               d_pmem_wdata = rnd128();
               if ($urandom_range(0, 3) == 0) new_d_req();
            end
         end else if (cyc == 1) begin
            rst = 1'b0;
         end

         if (granted) mem_lat = $urandom_range(0, 4);
         if (m_busy) begin
            pmem_resp = (mem_lat == 0);
            if (mem_lat != 0) mem_lat--;
         end else begin
            pmem_resp = ($urandom_range(0, 5) == 0);
         end
         pmem_rdata = rnd128();

         @(negedge clk);
         chk("pmem_read",    128'(pmem_read),    128'(m_busy & m_rd));
         chk("pmem_write",   128'(pmem_write),   128'(m_busy & m_wr));
         chk("pmem_address", 128'(pmem_address), 128'(m_addr));
         chk("pmem_wdata",   pmem_wdata,         m_wdata);
         chk("i_pmem_resp",  128'(i_pmem_resp),
             128'(m_busy && !m_port && pmem_resp && !rst));
         chk("d_pmem_resp",  128'(d_pmem_resp),
             128'(m_busy && m_port && pmem_resp && !rst));
         if (i_pmem_resp) chk("i_pmem_rdata", i_pmem_rdata, pmem_rdata);
         if (d_pmem_resp) chk("d_pmem_rdata", d_pmem_rdata, pmem_rdata);
      end

      chk("i_transactions_seen", 128'(n_done_i > 10), 128'(1));
      chk("d_transactions_seen", 128'(n_done_d > 10), 128'(1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
